// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - Operation/result handshake bundle for alu_seq
interface alu_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   operation;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag;

    modport slave (
        input  in_valid, operation, a, b, out_ready,
        output in_ready, out_valid, result, flag
    );

    modport master (
        output in_valid, operation, a, b, out_ready,
        input  in_ready, out_valid, result, flag
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - Sequential ALU with single-cycle ops plus iterative MATCH and MUL
// The first MATCH index / first MUL partial product is evaluated at accept so latencies are i+1 and W.
module alu_seq #(
    parameter int W = 8,
    parameter int P = 4
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] MATCH_LAST = CW'(W - P);
    localparam logic [CW-1:0] MUL_LAST   = CW'(W - 1);
    localparam logic [3:0]    OP_MATCH   = 4'd9;
    localparam logic [3:0]    OP_MUL     = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t         state_q;
    logic           is_mul_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   shb_q;
    logic [P-1:0]   pat_q;
    logic [W-1:0]   result_q;
    logic           flag_q;

    logic           accept;
    logic           hit0;
    logic [W:0]     sdiff;
    logic [W:0]     wide;
    logic [W-1:0]   alu_result_d;
    logic           alu_flag_d;
    logic [2*W-1:0] mul_sum_d;

    assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.flag      = flag_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign hit0      = (bus.a[P-1:0] == bus.b[P-1:0]);
    assign sdiff     = {bus.a[W-1], bus.a} - {bus.b[W-1], bus.b};
    // shb_q doubles as the MUL multiplier and the MATCH sliding window
    assign mul_sum_d = acc_q + (shb_q[0] ? mcand_q : '0);

    always_comb begin
        alu_result_d = '0;
        alu_flag_d   = 1'b0;
        wide         = '0;
        case (bus.operation)
            4'd0: alu_result_d = bus.a;
            4'd1: alu_result_d = sdiff[W] ? W'(~sdiff + (W+1)'(1)) : sdiff[W-1:0];
            4'd2: alu_result_d = bus.a >> 1;
            4'd3: alu_result_d = bus.a << 1;
            4'd4: begin
                wide = {1'b0, bus.a} + {1'b0, bus.b};
                {alu_flag_d, alu_result_d} = wide;
            end
            4'd5: begin
                wide = {1'b0, bus.a} + (W+1)'(1);
                {alu_flag_d, alu_result_d} = wide;
            end
            4'd6: begin
                alu_result_d = bus.a - W'(1);
                alu_flag_d   = (alu_result_d == '0);
            end
            4'd7: alu_result_d = (bus.a < bus.b) ? bus.a : bus.b;
            4'd8: begin
                alu_result_d = bus.a;
                alu_flag_d   = bus.a[W-1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            is_mul_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            shb_q    <= '0;
            pat_q    <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        cnt_q    <= CW'(1);
                        pat_q    <= bus.a[P-1:0];
                        shb_q    <= bus.b >> 1;
                        mcand_q  <= {W'(0), bus.a} << 1;
                        acc_q    <= bus.b[0] ? {W'(0), bus.a} : '0;
                        is_mul_q <= (bus.operation == OP_MUL);
                        if (bus.operation == OP_MUL) begin
                            state_q <= S_BUSY;
                        end else if (bus.operation == OP_MATCH) begin
                            if (hit0 || (MATCH_LAST == '0)) begin
                                state_q  <= S_DONE;
                                result_q <= '0;
                                flag_q   <= hit0;
                            end else begin
                                state_q <= S_BUSY;
                            end
                        end else begin
                            state_q  <= S_DONE;
                            result_q <= alu_result_d;
                            flag_q   <= alu_flag_d;
                        end
                    end else if ((state_q == S_DONE) && bus.out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + CW'(1);
                    shb_q <= shb_q >> 1;
                    if (is_mul_q) begin
                        acc_q   <= mul_sum_d;
                        mcand_q <= mcand_q << 1;
                        if (cnt_q == MUL_LAST) begin
                            state_q  <= S_DONE;
                            result_q <= mul_sum_d[W-1:0];
                            flag_q   <= |mul_sum_d[2*W-1:W];
                        end
                    end else if (shb_q[P-1:0] == pat_q) begin
                        state_q  <= S_DONE;
                        result_q <= W'(cnt_q);
                        flag_q   <= 1'b1;
                    end else if (cnt_q == MATCH_LAST) begin
                        state_q  <= S_DONE;
                        result_q <= '0;
                        flag_q   <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - Self-checking bench for alu_seq (W=8, P=4)
module tb_alu_seq;
    localparam int W = 8;
    localparam int P = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_seq_if #(.W(W)) bus ();

    alu_seq #(.W(W), .P(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: what each opcode must produce and after how many cycles
    function automatic void model_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [W-1:0] r, output logic f, output int lat);
        int     sx, sy, d, s;
        longint prod;
        logic [W-1:0] win;
        logic   found;
        r = '0; f = 1'b0; lat = 1;
        case (op)
            4'd0: r = x;
            4'd1: begin
                sx = $signed(x); sy = $signed(y); d = sx - sy;
                if (d < 0) d = -d;
                r = d[W-1:0];
            end
            4'd2: r = x >> 1;
            4'd3: r = x << 1;
            4'd4: begin s = int'(x) + int'(y); r = s[W-1:0]; f = (s >= (1 << W)); end
            4'd5: begin s = int'(x) + 1; r = s[W-1:0]; f = (s >= (1 << W)); end
            4'd6: begin r = x - 1; f = (r == 0); end
            4'd7: r = (x < y) ? x : y;
            4'd8: begin r = x; f = x[W-1]; end
            4'd9: begin
                found = 1'b0;
                lat = W - P + 1;
                for (int i = 0; i <= W - P; i++) begin
                    win = y >> i;
                    if (!found && (win[P-1:0] == x[P-1:0])) begin
                        found = 1'b1; r = W'(i); f = 1'b1; lat = i + 1;
                    end
                end
            end
            4'd10: begin
                prod = longint'(x) * longint'(y);
                r = prod[W-1:0];
                f = ((prod >> W) != 0);
                lat = W;
            end
            default: ;
        endcase
    endfunction

    logic         m_valid = 1'b0, m_pending = 1'b0, m_flag = 1'b0, p_flag = 1'b0;
    logic [W-1:0] m_res = '0, p_res = '0;
    int           m_wait = 0;

    function automatic logic exp_ready();
        return m_pending ? 1'b0 : (m_valid ? bus.out_ready : 1'b1);
    endfunction

    always @(posedge clk or posedge reset) begin
        logic         acc;
        logic [W-1:0] r;
        logic         f;
        int           lat;
        if (reset) begin
            m_valid = 1'b0; m_pending = 1'b0; m_wait = 0; m_res = '0; m_flag = 1'b0;
        end else begin
            acc = bus.in_valid && exp_ready();
            if (m_pending) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_pending = 1'b0; m_valid = 1'b1; m_res = p_res; m_flag = p_flag;
                end
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0;
            end
            if (acc) begin
                model_op(bus.operation, bus.a, bus.b, r, f, lat);
                if (lat == 1) begin
                    m_valid = 1'b1; m_res = r; m_flag = f;
                end else begin
                    m_valid = 1'b0; m_pending = 1'b1; m_wait = lat - 1; p_res = r; p_flag = f;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("cyc_in_ready", 32'(bus.in_ready), 32'(exp_ready()));
        chk("cyc_result", 32'(bus.result), 32'(m_res));
        chk("cyc_flag", 32'(bus.flag), 32'(m_flag));
    end

    task automatic run_op(input string nm, input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] er, input logic ef, input int el, input int idle);
        int   lat;
        logic seen;
        repeat (idle) @(posedge clk);
        #1;
        bus.in_valid = 1'b1; bus.operation = op; bus.a = av; bus.b = bv;
        #1;
        chk({nm, "_accept_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.a = ~av; bus.b = ~bv;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) seen = 1'b1;
            else chk({nm, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
        end
        chk({nm, "_latency"}, 32'(lat), 32'(el));
        chk({nm, "_result"}, 32'(bus.result), 32'(er));
        chk({nm, "_flag"}, 32'(bus.flag), 32'(ef));
    endtask

    initial begin
        int vcnt;
        bus.in_valid = 1'b0; bus.operation = 4'd0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_flag", 32'(bus.flag), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b0;

        run_op("add_carry", 4'd4, 8'hF0, 8'h20, 8'h10, 1'b1, 1, 0);
        run_op("dec_one", 4'd6, 8'h01, 8'h00, 8'h00, 1'b1, 1, 0);
        run_op("dec_zero", 4'd6, 8'h00, 8'h00, 8'hFF, 1'b0, 1, 1);
        run_op("absdiff", 4'd1, 8'hFE, 8'h03, 8'h05, 1'b0, 1, 0);
        run_op("min", 4'd7, 8'hFE, 8'h03, 8'h03, 1'b0, 1, 2);
        run_op("match_hit3", 4'd9, 8'h0B, 8'h58, 8'h03, 1'b1, 4, 0);
        run_op("match_miss", 4'd9, 8'h0F, 8'h00, 8'h00, 1'b0, 5, 1);
        run_op("match_hit0", 4'd9, 8'h05, 8'hA5, 8'h00, 1'b1, 1, 0);
        run_op("mul_ovf", 4'd10, 8'd20, 8'd13, 8'h04, 1'b1, 8, 0);
        run_op("mul_fit", 4'd10, 8'd15, 8'd17, 8'hFF, 1'b0, 8, 1);
        run_op("pass", 4'd0, 8'hA5, 8'h00, 8'hA5, 1'b0, 1, 0);
        run_op("lsr1", 4'd2, 8'h81, 8'h00, 8'h40, 1'b0, 1, 0);
        run_op("lsl1", 4'd3, 8'h81, 8'h00, 8'h02, 1'b0, 1, 1);
        run_op("inc_wrap", 4'd5, 8'hFF, 8'h00, 8'h00, 1'b1, 1, 0);
        run_op("neg", 4'd8, 8'h80, 8'h00, 8'h80, 1'b1, 1, 0);
        run_op("reserved", 4'd12, 8'h77, 8'h11, 8'h00, 1'b0, 1, 0);

        // Backpressure then back-to-back accept from DONE
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.operation = 4'd5; bus.a = 8'h41;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_first_valid", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_result", 32'(bus.result), 32'h42);
            chk("bp_hold_flag", 32'(bus.flag), 32'd0);
            chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        #1;
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.operation = 4'd0; bus.a = 8'h5A;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_result", 32'(bus.result), 32'h5A);

        // Reset three cycles into a MUL
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1; bus.operation = 4'd10; bus.a = 8'd20; bus.b = 8'd13;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_result", 32'(bus.result), 32'd0);
        chk("mrst_flag", 32'(bus.flag), 32'd0);
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        vcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) vcnt++;
        end
        chk("mrst_no_stale", 32'(vcnt), 32'd0);
        run_op("add_after_rst", 4'd4, 8'd7, 8'd9, 8'h10, 1'b0, 1, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL provide parameter W, default 8, meaning the operand/result width (legal W >= 4).
REQ-002 The block SHALL provide parameter P, default 4, meaning the MATCH pattern width (legal 1 <= P <= W).
REQ-003 The block SHALL provide port clk  input  1  meaning the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL provide port reset  input  1  meaning asynchronous, active-high reset.
REQ-005 The block SHALL provide port in_valid  input  1  meaning that operation, a and b are presented.
REQ-006 The block SHALL provide port in_ready  output  1  meaning the block can accept an operation this cycle.
REQ-007 The block SHALL provide port operation  input  4  meaning the opcode (REQ-013).
REQ-008 The block SHALL provide ports a and b  input  W each  meaning operands A and B.
REQ-009 The block SHALL provide port out_valid  output  1  meaning that result and flag are valid.
REQ-010 The block SHALL provide port out_ready  input  1  meaning the consumer takes the result this cycle.
REQ-011 The block SHALL provide ports result  output  W and flag  output  1  meaning the registered result and status flag.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, BUSY and DONE; accept = in_valid && in_ready; operands SHALL be captured at accept.
REQ-013 The block SHALL implement the following opcodes; widths are modulo 2^W unless stated; "flag=0" where no flag is given:
- 0 PASS: result=A.
- 1 ABSDIFF: result=|A-B| with A and B signed.
- 2 LSR1: result=A>>1.
- 3 LSL1: result=A<<1.
- 4 ADD: {flag,result}=A+B (flag = carry-out).
- 5 INC: {flag,result}=A+1.
- 6 DEC: result=A-1; flag=(result==0).
- 7 MIN: result = unsigned minimum of A and B.
- 8 NEG: result=A; flag=A[W-1].
- 9 MATCH: multi-cycle; see REQ-016.
- 10 MUL: multi-cycle; see REQ-017.
- 11-15 reserved: result=0, flag=0, single-cycle.
REQ-014 Single-cycle opcodes SHALL transition IDLE->DONE at accept, with out_valid=1 on the cycle after accept.
REQ-015 Multi-cycle opcodes SHALL transition IDLE->BUSY at accept; BUSY->DONE when the operation completes.
REQ-016 MATCH SHALL scan index i = 0..W-P, one index per BUSY cycle, comparing A[P-1:0] with B[i+P-1:i]:
- On the first hit: result=i, flag=1, and out_valid is asserted at accept+i+1.
- With no hit: result=0, flag=0, and out_valid is asserted at accept+W-P+1.
REQ-017 MUL SHALL be an unsigned shift-add over W BUSY cycles: result = low W bits of A*B; flag=1 if any of the high W bits is nonzero; out_valid is asserted at accept+W.
REQ-018 in_ready SHALL be 1 in IDLE, 0 in BUSY, and equal to out_ready in DONE.
REQ-019 In DONE, while out_ready=0, result, flag and out_valid SHALL hold stable (backpressure).
REQ-020 In DONE, when out_ready=1 and in_valid=0, the FSM SHALL go to IDLE and out_valid SHALL be 0 on the next cycle.
REQ-021 In DONE, when out_ready=1 and in_valid=1, the new operation SHALL be accepted in the same cycle:
- It follows REQ-014/015 directly, without passing through IDLE.
- For a single-cycle opcode, out_valid stays 1 with the new result on the next cycle.
REQ-022 in_valid in BUSY SHALL be ignored; operand inputs SHALL not affect an operation after accept.
REQ-023 result and flag SHALL change only on completion of an operation or on reset.
REQ-024 Iteration counters SHALL be sized $clog2(W+1) and SHALL not wrap before completion.

Reset
REQ-025 While reset=1, regardless of clk, the block SHALL force:
- state=IDLE, result=0, flag=0, out_valid=0, in_ready=1;
- internal counters and partial products cleared.
REQ-026 Reset asserted in BUSY or DONE SHALL abort the operation and discard its result; no out_valid pulse SHALL follow the deassertion of reset.
REQ-027 On the first clk edge after reset deasserts, the block SHALL be able to accept an operation.

Verification (W=8, P=4)
REQ-028 ADD, a=8'hF0, b=8'h20, out_ready=1 -> result=8'h10, flag=1, out_valid at accept+1; DEC a=8'h01 -> result=0, flag=1; DEC a=8'h00 -> result=8'hFF, flag=0.
REQ-029 ABSDIFF, a=8'hFE, b=8'h03 -> result=8'h05; MIN, a=8'hFE, b=8'h03 -> result=8'h03.
REQ-030 MATCH cases:
- a=8'h0B, b=8'h58 -> result=3, flag=1, out_valid at accept+4.
- a=8'h0F, b=8'h00 -> result=0, flag=0, out_valid at accept+5.
- in_ready=0 throughout BUSY in both cases.
REQ-031 MUL, a=20, b=13 -> result=8'h04, flag=1, out_valid at accept+8; MUL, a=15, b=17 -> result=8'hFF, flag=0.
REQ-032 Backpressure and back-to-back:
- Hold out_ready=0 for 5 cycles after an INC -> result, flag and out_valid stay stable, in_ready=0.
- Then out_ready=1 with in_valid=1 (PASS a=8'h5A) -> next cycle result=8'h5A with out_valid still 1.
REQ-033 Reset mid-operation: assert reset 3 cycles into a MUL -> out_valid=0, result=0, flag=0, in_ready=1 immediately; no stale completion follows; the next ADD completes correctly.
